// File: rtl/sysclk_wait_ctrl_if.sv
// CPU-side bus bundle for the system-clock / wait-state controller.
// The master modport is the CPU/bench side, and the slave modport is the controller.
interface sysclk_wait_ctrl_if;
    logic [7:0] adr_hi;
    logic [7:0] adr_lo;
    logic       rw;
    logic [7:0] dat_in;
    logic       rdy;
    logic       sys_clk;
    logic       stretch;
    logic       err;
    logic [7:0] cfg_q;

    modport master (
        output adr_hi, adr_lo, rw, dat_in, rdy,
        input  sys_clk, stretch, err, cfg_q
    );

    modport slave (
        input  adr_hi, adr_lo, rw, dat_in, rdy,
        output sys_clk, stretch, err, cfg_q
    );
endinterface

// File: rtl/sysclk_wait_ctrl.sv
// 6502 system-clock generator. It divides clk by 2 and can stretch the high
// phase of sys_clk. Accesses to the four 16-byte windows at 9F40-9F7F get
// 0..3 programmed wait states. A single access with W waits holds sys_clk
// high for 1+2W clk cycles. The wait counts are packed two bits per window
// into the config register at CFG_ADDR.
// Optional feature, macro RDY_WAIT_EN: an external rdy input extends a window
// access further. A timeout ends the extension and sets the sticky err flag.
module sysclk_wait_ctrl #(
    parameter logic [7:0]  IO_PAGE  = 8'h9F,
    parameter logic [15:0] CFG_ADDR = 16'h0002,
    parameter logic [7:0]  CFG_RST  = 8'h03,
    parameter int unsigned TMO      = 255
) (
    input logic                clk,
    input logic                rst,
    sysclk_wait_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {LOW, HIGH, WAIT, RDYWAIT} state_t;

    state_t      state, nextState;
    logic        hitQ;        // the current high phase is a window access
    logic [1:0]  wQ;          // wait count captured when the access started
    logic [2:0]  wCnt;        // remaining WAIT cycles minus one
    logic [7:0]  cfgQ;
    logic        hitNow;
    logic [1:0]  wNow;
    logic        leaveHigh;
    logic        cfgWr;

    // Live window decode. It is only used on the LOW->HIGH edge.
    assign hitNow = (bus.adr_hi == IO_PAGE) && (bus.adr_lo[7:6] == 2'b01);
    assign wNow   = cfgQ[{bus.adr_lo[5:4], 1'b0} +: 2];

    // The config write happens on the edge that ends the high phase.
    assign leaveHigh = (state != LOW) && (nextState == LOW);
    assign cfgWr     = leaveHigh && ({bus.adr_hi, bus.adr_lo} == CFG_ADDR) && !bus.rw;

`ifdef RDY_WAIT_EN
    logic [7:0] tCnt;
    logic       errQ;
    logic       timeout;

    assign timeout = (state == RDYWAIT) && !bus.rdy && (tCnt == 8'(TMO - 1));
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking, so all registers update together and no race follows from statement order.
        if (!rst) state <= LOW;
        else      state <= nextState;
    end

    // Next-state decode for the high-phase stretch.
    always_comb begin
        // NOTE: assign a default first so that no path through the case leaves nextState unassigned and infers a latch.
        nextState = LOW;
        case (state)
            LOW:  nextState = HIGH;
            HIGH: begin
                if (hitQ && (wQ != 2'd0))
                    nextState = WAIT;
`ifdef RDY_WAIT_EN
                else if (hitQ && !bus.rdy)
                    nextState = RDYWAIT;
`endif
                else
                    nextState = LOW;
            end
            WAIT: begin
                if (wCnt != 3'd0)
                    nextState = WAIT;
`ifdef RDY_WAIT_EN
                else if (!bus.rdy)
                    nextState = RDYWAIT;
`endif
                else
                    nextState = LOW;
            end
`ifdef RDY_WAIT_EN
            RDYWAIT: begin
                if (bus.rdy || (tCnt == 8'(TMO - 1))) nextState = LOW;
                else                                  nextState = RDYWAIT;
            end
`endif
            default: nextState = LOW;
        endcase
    end

    // Access capture, wait/timeout counters, config register and err flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hitQ <= 1'b0;
            wQ   <= 2'd0;
            wCnt <= 3'd0;
            cfgQ <= CFG_RST;
`ifdef RDY_WAIT_EN
            tCnt <= 8'd0;
            errQ <= 1'b0;
`endif
        end else begin
            if (state == LOW) begin
                hitQ <= hitNow;
                wQ   <= wNow;
                wCnt <= (hitNow && (wNow != 2'd0)) ? ({wNow, 1'b0} - 3'd1) : 3'd0;
            end else if ((state == WAIT) && (wCnt != 3'd0)) begin
                wCnt <= wCnt - 3'd1;
            end

            if (cfgWr) cfgQ <= bus.dat_in;

`ifdef RDY_WAIT_EN
            if ((nextState == RDYWAIT) && (state != RDYWAIT)) tCnt <= 8'd0;
            else if (state == RDYWAIT)                          tCnt <= tCnt + 8'd1;

            // A config write on the same edge clears err, even when a timeout happens then.
            if (cfgWr)        errQ <= 1'b0;
            else if (timeout) errQ <= 1'b1;
`endif
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        bus.sys_clk = (state != LOW);
        bus.stretch = (state == WAIT) || (state == RDYWAIT);
        bus.cfg_q   = cfgQ;
`ifdef RDY_WAIT_EN
        bus.err     = errQ;
`else
        bus.err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sysclk_wait_ctrl.sv
// Scoreboard bench for sysclk_wait_ctrl. Each access pushes the expected
// high-phase length, stretch length, err and cfg_q. A monitor measures every
// sys_clk high phase on negedge clk and checks it against the queue. It also
// checks that each low phase lasts exactly one clk.
module tb_sysclk_wait_ctrl;

    typedef struct {
        int         highLen;
        int         strLen;
        logic       err;
        logic [7:0] cfg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;

    sysclk_wait_ctrl_if bus ();

    sysclk_wait_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: measures each phase and compares it with the scoreboard.
    logic prevHigh   = 1'b0;
    logic lowPending = 1'b0;
    int   highCnt    = 0;
    int   strCnt     = 0;
    int   lowCnt     = 0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.sys_clk === 1'b1) begin
            if (!prevHigh) begin
                if (lowPending) check("low_phase_len", lowCnt, 1);
                lowPending = 1'b0;
                highCnt = 0;
                strCnt  = 0;
            end
            highCnt++;
            if (bus.stretch === 1'b1) strCnt++;
        end else begin
            if (prevHigh) begin
                if (expQ.size() == 0) begin
                    totalCnt++;
                    $display("FAIL unexpected_phase: high %0d with empty scoreboard", highCnt);
                end else begin
                    e = expQ.pop_front();
                    check("high_len", highCnt, e.highLen);
                    check("stretch_len", strCnt, e.strLen);
                    check("err", bus.err, e.err);
                    check("cfg_q", bus.cfg_q, e.cfg);
                end
                lowPending = 1'b1;
                lowCnt = 0;
            end
            lowCnt++;
        end
        prevHigh = (bus.sys_clk === 1'b1);
    end

    // Call this at a negedge in the LOW phase. It returns at the negedge after the high phase ends.
    task automatic access(input logic [15:0] adr, input logic rwIn, input logic [7:0] dat,
                          input logic rdyInit, input int relAt,
                          input int expHigh, input int expStr, input logic expErr,
                          input logic [7:0] expCfg);
        int k = 0;
        int guard = 0;
        bus.adr_hi = adr[15:8];
        bus.adr_lo = adr[7:0];
        bus.rw     = rwIn;
        bus.dat_in = dat;
        bus.rdy    = rdyInit;
        expQ.push_back('{expHigh, expStr, expErr, expCfg});
        do begin
            @(negedge clk);
            guard++;
            if (bus.sys_clk === 1'b1) begin
                k++;
                if (k == relAt) bus.rdy = 1'b1;
            end
        end while ((k == 0 || bus.sys_clk === 1'b1) && guard < 600);
        if (guard >= 600) begin
            totalCnt++;
            $display("FAIL access_bound: adr %04h still high after %0d clk", adr, guard);
        end
        bus.rdy = 1'b1;
    endtask

    initial begin
        int n;
        int guard;
        bus.adr_hi = 8'h12;
        bus.adr_lo = 8'h34;
        bus.rw     = 1'b1;
        bus.dat_in = 8'h00;
        bus.rdy    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sys_clk", bus.sys_clk, 1'b0);
        check("rst_stretch", bus.stretch, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_cfg_q", bus.cfg_q, 8'h03);
        rst = 1'b1;

        // Non-hit accesses: 1 clk high and 1 clk low.
        repeat (3) access(16'h1234, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h03);
        // Window 0 with 3 waits: 7 high, 6 of them stretched. Then period 2 again.
        access(16'h9F40, 1'b1, 8'h00, 1'b1, 0, 7, 6, 1'b0, 8'h03);
        access(16'h1234, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h03);
        // Program 0xE4, which sets windows 0..3 to 0..3 waits.
        access(16'h0002, 1'b0, 8'hE4, 1'b1, 0, 1, 0, 1'b0, 8'hE4);
        access(16'h9F40, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'hE4);
        access(16'h9F50, 1'b1, 8'h00, 1'b1, 0, 3, 2, 1'b0, 8'hE4);
        access(16'h9F60, 1'b1, 8'h00, 1'b1, 0, 5, 4, 1'b0, 8'hE4);
        access(16'h9F7F, 1'b1, 8'h00, 1'b1, 0, 7, 6, 1'b0, 8'hE4);
        // Addresses next to the windows must not be stretched.
        access(16'h9F80, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'hE4);
        access(16'h9F3F, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'hE4);
        access(16'h8F70, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'hE4);
        // A write to 0x0003 is not a config write.
        access(16'h0003, 1'b0, 8'h55, 1'b1, 0, 1, 0, 1'b0, 8'hE4);

`ifdef RDY_WAIT_EN
        // W=1 and rdy low for 5 more clk: 3+5 high, 7 stretched.
        access(16'h9F50, 1'b1, 8'h00, 1'b0, 8, 8, 7, 1'b0, 8'hE4);
        // rdy stuck low on a W=0 window: HIGH plus 255 RDYWAIT clk, then err.
        access(16'h9F40, 1'b1, 8'h00, 1'b0, 0, 256, 255, 1'b1, 8'hE4);
        // err is sticky across a plain access.
        access(16'h1234, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b1, 8'hE4);
`else
        // rdy is ignored: only the programmed wait applies.
        access(16'h9F50, 1'b1, 8'h00, 1'b0, 0, 3, 2, 1'b0, 8'hE4);
        access(16'h9F40, 1'b1, 8'h00, 1'b0, 0, 1, 0, 1'b0, 8'hE4);
`endif
        // Writing 0x00 clears err and all waits.
        access(16'h0002, 1'b0, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h00);
        access(16'h9F40, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h00);
        access(16'h9F70, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h00);

        // Reset during the 4th WAIT cycle of a 3-wait access, with cfg 0x07.
        access(16'h0002, 1'b0, 8'h07, 1'b1, 0, 1, 0, 1'b0, 8'h07);
        expQ.push_back('{5, 4, 1'b0, 8'h03});
        bus.adr_hi = 8'h9F;
        bus.adr_lo = 8'h40;
        bus.rw     = 1'b1;
        n = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (bus.stretch === 1'b1) n++;
        end while (n < 4 && guard < 50);
        check("abort_reached_wait4", n, 4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_sys_clk", bus.sys_clk, 1'b0);
        check("abort_stretch", bus.stretch, 1'b0);
        check("abort_cfg_q", bus.cfg_q, 8'h03);
        // The first cycle after reset runs cleanly with the reset config.
        access(16'h1234, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1'b0, 8'h03);
        access(16'h9F40, 1'b1, 8'h00, 1'b1, 0, 7, 6, 1'b0, 8'h03);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
